// File: rtl/vip_avalon_st_video_encoder_if.sv
// Avalon-ST Video encoder bundle: filter pixel input, control-packet request and framed output.
// master is the encoder's own view; slave is the view of the surrounding fabric.
interface vip_avalon_st_video_encoder_if #(
  parameter int BITS_PER_SYMBOL  = 8,
  parameter int SYMBOLS_PER_BEAT = 3
);
  localparam int DW = BITS_PER_SYMBOL * SYMBOLS_PER_BEAT;

  logic          din_ready;
  logic          din_valid;
  logic [DW-1:0] din_data;
  logic          encoder_end_of_video;
  logic [15:0]   encoder_width;
  logic [15:0]   encoder_height;
  logic [3:0]    encoder_interlaced;
  logic          encoder_vip_ctrl_send;
  logic          encoder_vip_ctrl_busy;
  logic          dout_ready;
  logic          dout_valid;
  logic [DW-1:0] dout_data;
  logic          dout_startofpacket;
  logic          dout_endofpacket;
  logic          frame_error;

  modport master (
    output din_ready, encoder_vip_ctrl_busy, dout_valid, dout_data,
           dout_startofpacket, dout_endofpacket, frame_error,
    input  din_valid, din_data, encoder_end_of_video, encoder_width,
           encoder_height, encoder_interlaced, encoder_vip_ctrl_send, dout_ready
  );

  modport slave (
    input  din_ready, encoder_vip_ctrl_busy, dout_valid, dout_data,
           dout_startofpacket, dout_endofpacket, frame_error,
    output din_valid, din_data, encoder_end_of_video, encoder_width,
           encoder_height, encoder_interlaced, encoder_vip_ctrl_send, dout_ready
  );
endinterface

// File: rtl/vip_avalon_st_video_encoder.sv
// Avalon-ST Video transmit packetiser: frames control packets (type 0xF) and video
// packets (type 0x0) behind a single registered output beat with zero-bubble streaming.
module vip_avalon_st_video_encoder #(
  parameter int BITS_PER_SYMBOL  = 8,
  parameter int SYMBOLS_PER_BEAT = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  vip_avalon_st_video_encoder_if.master   bus
);

  localparam int DW         = BITS_PER_SYMBOL * SYMBOLS_PER_BEAT;
  localparam int CTRL_BEATS = (9 + SYMBOLS_PER_BEAT - 1) / SYMBOLS_PER_BEAT;
  localparam logic [3:0] LAST_IDX = 4'(CTRL_BEATS - 1);

  typedef enum logic [2:0] {
    IDLE,
    CTRL_HDR,
    CTRL_DATA,
    VID_HDR,
    VID_DATA
  } state_t;

  state_t        state, state_nx;
  logic [15:0]   width_q, height_q;
  logic [3:0]    interlaced_q;
  logic          pending, busy;
  logic [3:0]    ctrl_idx, idx_nx;
  logic [31:0]   pix_cnt, cnt_next, exp_cnt;

  logic          vld_p0, sop_p0, eop_p0, ctrl_last_p0;
  logic [DW-1:0] data_p0;
  logic          frame_error_p1;

  logic          can_load, take_send, pix_acc, frame_last;
  logic          load, sop_nx, eop_nx, ctrl_last_nx, pending_clr, cnt_clr;
  logic [DW-1:0] beat_nx;

  function automatic logic [3:0] ctrl_nibble(input logic [15:0] w, input logic [15:0] h,
                                             input logic [3:0] il, input int n);
    case (n)
      0:       return w[15:12];
      1:       return w[11:8];
      2:       return w[7:4];
      3:       return w[3:0];
      4:       return h[15:12];
      5:       return h[11:8];
      6:       return h[7:4];
      7:       return h[3:0];
      8:       return il;
      default: return 4'h0;
    endcase
  endfunction

  // Nibbles past the ninth fall into the default branch, zeroing unused trailing symbols.
  function automatic logic [DW-1:0] ctrl_beat(input logic [3:0] idx, input logic [15:0] w,
                                              input logic [15:0] h, input logic [3:0] il);
    logic [DW-1:0] b;
    b = '0;
    for (int s = 0; s < SYMBOLS_PER_BEAT; s++) begin
      b[s*BITS_PER_SYMBOL +: 4] = ctrl_nibble(w, h, il, int'(idx) * SYMBOLS_PER_BEAT + s);
    end
    return b;
  endfunction

  function automatic logic [DW-1:0] header_beat(input logic [3:0] pkt_type);
    logic [DW-1:0] b;
    b      = '0;
    b[3:0] = pkt_type;
    return b;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign can_load   = ~vld_p0 | bus.dout_ready;
  assign take_send  = bus.encoder_vip_ctrl_send & ~busy;
  assign bus.din_ready = (state == VID_DATA) & can_load;
  assign pix_acc    = bus.din_ready & bus.din_valid;
  assign frame_last = pix_acc & bus.encoder_end_of_video;
  assign cnt_next   = sat_inc(pix_cnt);
  assign exp_cnt    = {16'd0, width_q} * {16'd0, height_q};

  always_comb begin
    state_nx     = state;
    idx_nx       = ctrl_idx;
    load         = 1'b0;
    beat_nx      = '0;
    sop_nx       = 1'b0;
    eop_nx       = 1'b0;
    ctrl_last_nx = 1'b0;
    pending_clr  = 1'b0;
    cnt_clr      = 1'b0;
    case (state)
      IDLE: begin
        if (pending | take_send)  state_nx = CTRL_HDR;
        else if (bus.din_valid)   state_nx = VID_HDR;
      end
      CTRL_HDR: begin
        if (can_load) begin
          load     = 1'b1;
          beat_nx  = header_beat(4'hF);
          sop_nx   = 1'b1;
          idx_nx   = 4'd0;
          state_nx = CTRL_DATA;
        end
      end
      CTRL_DATA: begin
        if (can_load) begin
          load    = 1'b1;
          beat_nx = ctrl_beat(ctrl_idx, width_q, height_q, interlaced_q);
          if (ctrl_idx == LAST_IDX) begin
            eop_nx       = 1'b1;
            ctrl_last_nx = 1'b1;
            pending_clr  = 1'b1;
            state_nx     = IDLE;
          end else begin
            idx_nx = ctrl_idx + 4'd1;
          end
        end
      end
      VID_HDR: begin
        if (can_load) begin
          load     = 1'b1;
          beat_nx  = header_beat(4'h0);
          sop_nx   = 1'b1;
          cnt_clr  = 1'b1;
          state_nx = VID_DATA;
        end
      end
      VID_DATA: begin
        if (pix_acc) begin
          load    = 1'b1;
          beat_nx = bus.din_data;
          eop_nx  = bus.encoder_end_of_video;
          if (bus.encoder_end_of_video) state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      ctrl_idx     <= 4'd0;
      width_q      <= 16'd640;
      height_q     <= 16'd480;
      interlaced_q <= 4'd0;
      pending      <= 1'b0;
      busy         <= 1'b0;
      pix_cnt      <= 32'd0;
    end else begin
      state    <= state_nx;
      ctrl_idx <= idx_nx;
      if (take_send) begin
        width_q      <= bus.encoder_width;
        height_q     <= bus.encoder_height;
        interlaced_q <= bus.encoder_interlaced;
        pending      <= 1'b1;
        busy         <= 1'b1;
      end else begin
        if (pending_clr) pending <= 1'b0;
        // busy outlives pending until the control eop beat actually leaves the register
        if (vld_p0 & bus.dout_ready & ctrl_last_p0) busy <= 1'b0;
      end
      if (cnt_clr)      pix_cnt <= 32'd0;
      else if (pix_acc) pix_cnt <= cnt_next;
    end
  end

  // ---- stage p0: output beat register ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p0       <= 1'b0;
      data_p0      <= '0;
      sop_p0       <= 1'b0;
      eop_p0       <= 1'b0;
      ctrl_last_p0 <= 1'b0;
    end else if (load) begin
      vld_p0       <= 1'b1;
      data_p0      <= beat_nx;
      sop_p0       <= sop_nx;
      eop_p0       <= eop_nx;
      ctrl_last_p0 <= ctrl_last_nx;
    end else if (bus.dout_ready) begin
      vld_p0       <= 1'b0;
      ctrl_last_p0 <= 1'b0;
    end
  end

  // ---- stage p1: end-of-frame count check ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) frame_error_p1 <= 1'b0;
    else      frame_error_p1 <= frame_last & (cnt_next != exp_cnt);
  end

  assign bus.dout_valid            = vld_p0;
  assign bus.dout_data             = data_p0;
  assign bus.dout_startofpacket    = sop_p0;
  assign bus.dout_endofpacket      = eop_p0;
  assign bus.encoder_vip_ctrl_busy = busy;
  assign bus.frame_error           = frame_error_p1;

endmodule

// File: tb/tb_vip_avalon_st_video_encoder.sv
// Scoreboard bench for the Avalon-ST Video encoder: stimulus pushes expected beats,
// a negedge monitor pops and compares every transferred output beat.
module tb_vip_avalon_st_video_encoder;
  localparam int B  = 8;
  localparam int S  = 3;
  localparam int DW = B * S;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vip_avalon_st_video_encoder_if #(.BITS_PER_SYMBOL(B), .SYMBOLS_PER_BEAT(S)) bus ();

  vip_avalon_st_video_encoder #(.BITS_PER_SYMBOL(B), .SYMBOLS_PER_BEAT(S)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
    logic          ctrl;
  } beat_t;

  beat_t exp_q[$];
  int    n_cmp = 0;
  int    n_err = 0;
  int    fe_pulses = 0;
  int    ready_mode = 0;
  bit    chk_busy = 0;
  bit    ctrl_eop_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push_beat(input logic [DW-1:0] d, input logic sop, input logic eop, input logic ctrl);
    beat_t b;
    b.data = d; b.sop = sop; b.eop = eop; b.ctrl = ctrl;
    exp_q.push_back(b);
  endtask

  task automatic push_ctrl(input logic [DW-1:0] c1, input logic [DW-1:0] c2, input logic [DW-1:0] c3);
    push_beat(24'h00000F, 1'b1, 1'b0, 1'b1);
    push_beat(c1, 1'b0, 1'b0, 1'b1);
    push_beat(c2, 1'b0, 1'b0, 1'b1);
    push_beat(c3, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(posedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: %0d beats outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_dout_valid"}, 32'(bus.dout_valid), 32'd0);
    check({tag, "_sop"},        32'(bus.dout_startofpacket), 32'd0);
    check({tag, "_eop"},        32'(bus.dout_endofpacket), 32'd0);
    check({tag, "_dout_data"},  32'(bus.dout_data), 32'd0);
    check({tag, "_din_ready"},  32'(bus.din_ready), 32'd0);
    check({tag, "_busy"},       32'(bus.encoder_vip_ctrl_busy), 32'd0);
    check({tag, "_frame_error"}, 32'(bus.frame_error), 32'd0);
  endtask

  task automatic run_ctrl(input logic [15:0] w, input logic [15:0] h, input logic [3:0] il,
                          input logic [DW-1:0] c1, input logic [DW-1:0] c2, input logic [DW-1:0] c3,
                          input bit extra_send);
    push_ctrl(c1, c2, c3);
    bus.encoder_width = w; bus.encoder_height = h; bus.encoder_interlaced = il;
    bus.encoder_vip_ctrl_send = 1'b1;
    @(posedge clk); #1;
    bus.encoder_vip_ctrl_send = 1'b0;
    chk_busy = 1'b1;
    bus.encoder_width = 16'hFFFF; bus.encoder_height = 16'hFFFF; bus.encoder_interlaced = 4'hF;
    if (extra_send) begin
      @(posedge clk); #1;
      bus.encoder_vip_ctrl_send = 1'b1;
      @(posedge clk); #1;
      bus.encoder_vip_ctrl_send = 1'b0;
    end
    drain();
  endtask

  task automatic run_frame(input int n, input logic [DW-1:0] base, input logic exp_fe,
                           input int send_at, input logic [15:0] sw, input logic [15:0] sh,
                           input logic [3:0] si, input logic [DW-1:0] c1,
                           input logic [DW-1:0] c2, input logic [DW-1:0] c3);
    bit acc;
    int t;
    if (send_at == 0) push_ctrl(c1, c2, c3);
    push_beat('0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) push_beat(base + DW'(i), 1'b0, (i == n - 1), 1'b0);
    if (send_at > 0) push_ctrl(c1, c2, c3);
    for (int i = 0; i < n; i++) begin
      acc = 1'b0;
      t = 0;
      bus.din_valid = 1'b1;
      bus.din_data = base + DW'(i);
      bus.encoder_end_of_video = (i == n - 1);
      if (i == send_at) begin
        bus.encoder_width = sw; bus.encoder_height = sh; bus.encoder_interlaced = si;
        bus.encoder_vip_ctrl_send = 1'b1;
      end
      while (!acc && t < 300) begin
        @(negedge clk);
        acc = bus.din_ready;
        @(posedge clk); #1;
        if (bus.encoder_vip_ctrl_send) begin
          bus.encoder_vip_ctrl_send = 1'b0;
          chk_busy = 1'b1;
        end
        t++;
      end
      if (!acc) begin
        n_cmp++;
        n_err++;
        $display("FAIL pixel_timeout: pixel %0d not accepted, expected acceptance", i);
        break;
      end
    end
    bus.din_valid = 1'b0;
    bus.encoder_end_of_video = 1'b0;
    @(negedge clk);
    check("frame_error", 32'(bus.frame_error), 32'(exp_fe));
    @(negedge clk);
    check("frame_error_width", 32'(bus.frame_error), 32'd0);
    drain();
  endtask

  // Sink ready driver
  initial begin
    bit rpat [4];
    int k;
    rpat = '{1'b1, 1'b0, 1'b0, 1'b1};
    k = 0;
    bus.dout_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        1:       bus.dout_ready = rpat[k % 4];
        2:       bus.dout_ready = 1'b0;
        default: bus.dout_ready = 1'b1;
      endcase
      k++;
    end
  end

  // Monitor / scoreboard
  initial begin
    logic          prev_stall;
    logic [DW+1:0] prev;
    beat_t         e;
    prev_stall = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) begin
        prev_stall = 1'b0;
        ctrl_eop_seen = 1'b0;
        chk_busy = 1'b0;
      end else begin
        if (chk_busy) begin
          check("busy_after_send", 32'(bus.encoder_vip_ctrl_busy), 32'd1);
          chk_busy = 1'b0;
        end
        if (ctrl_eop_seen) begin
          check("busy_clear_after_eop", 32'(bus.encoder_vip_ctrl_busy), 32'd0);
          ctrl_eop_seen = 1'b0;
        end
        if (prev_stall)
          check("hold_stable", 32'({bus.dout_valid, bus.dout_data, bus.dout_startofpacket, bus.dout_endofpacket}),
                32'({1'b1, prev}));
        if (bus.dout_valid && !bus.dout_ready)
          check("din_ready_stall", 32'(bus.din_ready), 32'd0);
        if (bus.dout_valid && bus.dout_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_beat: got data 0x%0h sop %0b eop %0b, expected no beat",
                     bus.dout_data, bus.dout_startofpacket, bus.dout_endofpacket);
          end else begin
            e = exp_q.pop_front();
            check("beat{data,sop,eop}", 32'({bus.dout_data, bus.dout_startofpacket, bus.dout_endofpacket}),
                  32'({e.data, e.sop, e.eop}));
            if (e.ctrl) check("busy_during_ctrl", 32'(bus.encoder_vip_ctrl_busy), 32'd1);
            if (e.ctrl && e.eop) ctrl_eop_seen = 1'b1;
          end
        end
        prev_stall = bus.dout_valid & ~bus.dout_ready;
        prev = {bus.dout_data, bus.dout_startofpacket, bus.dout_endofpacket};
        if (bus.frame_error) fe_pulses++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    bus.din_valid = 1'b0;
    bus.din_data = '0;
    bus.encoder_end_of_video = 1'b0;
    bus.encoder_width = 16'd0;
    bus.encoder_height = 16'd0;
    bus.encoder_interlaced = 4'd0;
    bus.encoder_vip_ctrl_send = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b1;
    @(posedge clk); #1;

    // 640x480 progressive control packet
    run_ctrl(16'd640, 16'd480, 4'd0, 24'h080200, 24'h010000, 24'h00000E, 1'b0);
    // 4x2 control packet followed by an ignored send while busy
    run_ctrl(16'd4, 16'd2, 4'd0, 24'h000000, 24'h000004, 24'h000200, 1'b1);
    // 4x2 video frame, free-flowing sink
    run_frame(8, 24'h000001, 1'b0, -1, 16'd0, 16'd0, 4'd0, '0, '0, '0);
    // same frame with sink ready pattern 1,0,0,1
    ready_mode = 1;
    run_frame(8, 24'h000010, 1'b0, -1, 16'd0, 16'd0, 4'd0, '0, '0, '0);
    ready_mode = 0;
    repeat (2) @(posedge clk); #1;
    // send arrives mid-video: 2x4 interlaced=5 control packet follows the video eop
    run_frame(8, 24'h000020, 1'b0, 3, 16'd2, 16'd4, 4'd5, 24'h000000, 24'h000002, 24'h050400);
    // simultaneous send and pixel in IDLE, short frame of 7 against 2x4
    run_frame(7, 24'h000030, 1'b1, 0, 16'd2, 16'd4, 4'd0, 24'h000000, 24'h000002, 24'h000400);

    // reset asserted while a header beat is stalled on the output
    ready_mode = 2;
    repeat (2) @(posedge clk); #1;
    bus.din_valid = 1'b1;
    bus.din_data = 24'h0000AA;
    repeat (4) @(posedge clk);
    #3;
    check("pre_reset_valid", 32'(bus.dout_valid), 32'd1);
    check("pre_reset_sop", 32'(bus.dout_startofpacket), 32'd1);
    rst = 1'b0;
    #1;
    check_outputs_zero("midreset");
    bus.din_valid = 1'b0;
    ready_mode = 0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    // defaults 640x480 apply again, so a 2-pixel frame is flagged
    run_frame(2, 24'h000040, 1'b1, -1, 16'd0, 16'd0, 4'd0, '0, '0, '0);

    check("frame_error_pulses", 32'(fe_pulses), 32'd2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vip_avalon_st_video_encoder.md
Name: vip_avalon_st_video_encoder

Overview:
Transmit-side Avalon-ST Video packetiser feeding the VIP output stream. It takes the filter's ready/valid pixel stream plus a control-packet request (width/height/interlaced, send/busy, end_of_video). It emits framed Avalon-ST Video: control packets (type 0xF) and video packets (type 0x0) with startofpacket/endofpacket. It is the encoder end of the flow-control wrapper's encoder interface.

Parameters:
BITS_PER_SYMBOL, 8, bits per symbol; must be >= 4.
SYMBOLS_PER_BEAT, 3, symbols per beat; supported values 1, 2, 3. Symbol 0 sits at the data LSBs.

Ports:
clk  in  1  clock; all logic on rising edge.
rst  in  1  asynchronous, active-low reset.
din_ready  out  1  pixel accepted when din_ready & din_valid.
din_valid  in  1  pixel beat valid.
din_data  in  BITS_PER_SYMBOL*SYMBOLS_PER_BEAT  pixel beat.
encoder_end_of_video  in  1  qualifies the din beat as the last pixel of the frame.
encoder_width  in  16  frame width, sampled on send.
encoder_height  in  16  frame height, sampled on send.
encoder_interlaced  in  4  interlace nibble, sampled on send.
encoder_vip_ctrl_send  in  1  one-cycle control-packet request.
encoder_vip_ctrl_busy  out  1  control packet pending or in flight.
dout_ready  in  1  sink ready, readyLatency 0.
dout_valid  out  1  output beat valid.
dout_data  out  BITS_PER_SYMBOL*SYMBOLS_PER_BEAT  output beat.
dout_startofpacket  out  1  first beat of a packet.
dout_endofpacket  out  1  last beat of a packet.
frame_error  out  1  one-cycle pulse: pixel count at end of frame differs from width*height.

Behaviour:
- Reset (rst=0, async): dout_valid, dout_startofpacket, dout_endofpacket, dout_data, din_ready, encoder_vip_ctrl_busy and frame_error are all 0. Latched width=640, height=480, interlaced=0. FSM=IDLE. Pixel counter=0.
- Output register: dout_* are registered and hold while dout_valid & ~dout_ready. A beat transfers on dout_valid & dout_ready. A new beat may load in the same cycle the current one transfers. No bubbles are inserted when both sides stream.
- din_ready = (state==VID_DATA) & (~dout_valid | dout_ready). It is combinational from registered state and dout_ready. An accepted pixel appears on dout the next cycle, so latency is 1.
- Send handling: send sampled while busy=0 latches width/height/interlaced and sets a pending flag. busy=1 from the next cycle until the cycle after the last control beat transfers. Send while busy=1 is ignored and the latched values are unchanged.
- FSM states:
  - IDLE: if pending, go to CTRL_HDR. Else if din_valid, go to VID_HDR. If both, control goes first.
  - CTRL_HDR: load beat {0…, 0xF in symbol0 [3:0]} with sop=1. When it transfers, go to CTRL_DATA.
  - CTRL_DATA: emit 9 nibbles in this order: w[15:12], w[11:8], w[7:4], w[3:0], h[15:12], h[11:8], h[7:4], h[3:0], interlaced.
    - Each nibble goes in bits [3:0] of successive symbols, symbol 0 first. Upper symbol bits are 0.
    - Beat count is ceil(9/SYMBOLS_PER_BEAT). Unused trailing symbols are 0.
    - eop=1 on the final beat. When it transfers, clear pending and busy, then go to IDLE.
  - VID_HDR: load beat with symbol0 = 0x0 and sop=1. Clear the pixel counter. When it transfers, go to VID_DATA.
  - VID_DATA: pass pixels with sop=0 and increment the 32-bit pixel counter, saturating at 2^32-1.
    - An accepted pixel with encoder_end_of_video=1 is loaded with eop=1, and the FSM goes to IDLE.
    - frame_error pulses 1 cycle after that acceptance if counter+1 != width*height. The product is 32 bits.
- A send arriving during VID_HDR or VID_DATA is latched (busy=1). The control packet is sent only after the video packet's eop beat; packets never interleave.
- encoder_end_of_video is ignored unless it coincides with an accepted pixel.
- A video packet with no preceding control packet uses the reset defaults for the frame_error check.
- A width or height of 0 yields an expected count of 0, so any non-empty frame flags frame_error.
- Reset asserted mid-packet aborts immediately: dout_valid=0 and no eop is emitted; the sink must tolerate the truncation.

Test Plan:
- Reset mid-stream: assert rst=0 while dout_valid=1 -> all outputs 0 asynchronously; after release the FSM is IDLE and the next packet starts with a header.
- Control packet, S=3, dout_ready=1: send with 640x480, interlaced=0 -> beats 0x00000F (sop), 0x080200, 0x010000, 0x00000E (eop). busy=1 for exactly these 4 transfer cycles plus the request cycle+1 alignment.
- Video 4x2 frame: 8 pixels 0x000001..0x000008, end_of_video on the 8th -> header 0x000000 (sop), the 8 pixels each 1 cycle after acceptance, eop on 0x000008, frame_error=0.
- Backpressure: during video, toggle dout_ready 1,0,0,1 -> dout_data and dout_valid stay stable while ready=0, din_ready=0 in the stall cycles, no pixel lost or duplicated.
- Send during video at pixel 3 of 8 -> busy=1 immediately after; the control packet header appears on the cycle after the video eop transfers, with the new width/height.
- Simultaneous send and din_valid in IDLE -> control packet fully precedes the video header. A 7-pixel frame with width*height=8 -> frame_error pulses once, 1 cycle after the last pixel is accepted.
